data_mem_responder: RTL and testbench

Responder side of the processor's data-memory interface: accepts one load/store request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. It applies byte-lane write enables and flags misaligned or out-of-range accesses. The block replaces the combinational data memory behind the CPU's load/store path so the core can be tested against realistic multi-cycle memory.

---
 rtl/data_mem_responder_if.sv | 47 ++++
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//
// Purpose: groups the load/store request channel and the response channel
// that sit between the CPU load/store path and the data-memory responder.
//
// Signals:
//   req_valid   requester -> responder  request present
//   req_ready   responder -> requester  responder can accept a request
//   req_write   requester -> responder  1 = store, 0 = load
//   req_addr    requester -> responder  byte address
//   req_wdata   requester -> responder  store data
//   req_be      requester -> responder  byte-lane write enables
//   resp_valid  responder -> requester  response present
//   resp_ready  requester -> responder  requester consumes the response
//   resp_rdata  responder -> requester  load data (0 for stores and errors)
//   resp_err    responder -> requester  misaligned or out-of-range access
//
// Modports: master (CPU side), slave (memory responder side).
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDRESS_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose: responder side of the processor data-memory interface. Accepts one
// load/store at a time, answers LATENCY cycles after the request handshake,
// applies byte-lane write enables and flags misaligned or out-of-range
// accesses. Memory contents survive reset.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset (0 = reset)
//   bus        data_mem_responder_if slave modport (request + response)
//   err_count  saturating 16-bit count of error responses
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [15:0]          err_count
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_BITS    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT = ADDRESS_WIDTH'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      write_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [BYTES-1:0]          be_q;
  logic                      reqReady_q;
  logic                      respValid_q;
  logic [DATA_WIDTH-1:0]     respRdata_q;
  logic                      respErr_q;
  logic [15:0]               errCount_q;

  logic [DATA_WIDTH-1:0]     mem [DEPTH_WORDS];

  logic                      handshake;
  logic                      enterResp;
  logic                      accWrite;
  logic [ADDRESS_WIDTH-1:0]  accAddr;
  logic [DATA_WIDTH-1:0]     accWdata;
  logic [BYTES-1:0]          accBe;
  logic [IDX_BITS-1:0]       accIdx;
  logic                      accErr;
  logic [DATA_WIDTH-1:0]     accRword;
  logic [DATA_WIDTH-1:0]     respRdata_d;
  logic                      respErr_d;
  logic [15:0]               errCount_d;

  // Access decode. With LATENCY == 1 the commit edge is the handshake edge
  // itself, so the live request fields are used in IDLE and the latched
  // copies otherwise. The commit is gated by rst so a reset arriving on the
  // final BUSY edge drops the pending store.
  always_comb begin
    handshake   = bus.req_valid & reqReady_q;
    accWrite    = (state_q == IDLE) ? bus.req_write : write_q;
    accAddr     = (state_q == IDLE) ? bus.req_addr  : addr_q;
    accWdata    = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    accBe       = (state_q == IDLE) ? bus.req_be    : be_q;
    accIdx      = accAddr[OFFSET_BITS +: IDX_BITS];
    accErr      = ((accAddr & OFFSET_MASK) != '0) ||
                  ((accAddr >> OFFSET_BITS) >= DEPTH_LIMIT);
    accRword    = mem[accIdx];
    enterResp   = rst && (((state_q == IDLE) && handshake && (LATENCY == 1)) ||
                          ((state_q == BUSY) && (cnt_q == CNT_W'(1))));
    respRdata_d = (accErr || accWrite) ? '0 : accRword;
    respErr_d   = accErr;
    errCount_d  = (accErr && (errCount_q != 16'hFFFF)) ? errCount_q + 16'd1 : errCount_q;
  end

  // Storage array, deliberately outside reset so contents persist. Only
  // enabled lanes of an error-free store are written on the commit edge.
  always_ff @(posedge clk) begin
    if (enterResp && accWrite && !accErr) begin
      for (int i = 0; i < BYTES; i++) begin
        if (accBe[i]) begin
          mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
        end
      end
    end
  end

  // Request/response sequencer with registered handshake outputs. The
  // response registers are loaded on the commit edge after the case so that
  // both the LATENCY == 1 and the countdown paths share one capture point.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      reqReady_q  <= 1'b0;
      respValid_q <= 1'b0;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
      errCount_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (handshake) begin
            write_q    <= bus.req_write;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            be_q       <= bus.req_be;
            cnt_q      <= CNT_W'(LATENCY - 1);
            reqReady_q <= 1'b0;
            state_q    <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q     <= IDLE;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (enterResp) begin
        respValid_q <= 1'b1;
        respRdata_q <= respRdata_d;
        respErr_q   <= respErr_d;
        errCount_q  <= errCount_d;
      end
    end
  end

  assign bus.req_ready  = reqReady_q;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.resp_err   = respErr_q;
  assign err_count      = errCount_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Purpose: directed bench for data_mem_responder. Two instances are built,
// one with LATENCY = 2 and one with LATENCY = 4; they share the request
// stimulus and a select picks which one is being exercised while the other
// is held in reset. A transaction-level memory model predicts every cycle of
// the selected instance, and hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst2;
  logic        rst4;
  logic        sel;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqBe;
  logic        respReady;
  logic [15:0] errCount2;
  logic [15:0] errCount4;

  logic        reqReady;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic [15:0] errCount;
  logic        rstSel;

  int nChecks = 0;
  int nPass   = 0;
  int cycle   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  data_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus4 ();

  assign bus2.req_valid  = reqValid;
  assign bus2.req_write  = reqWrite;
  assign bus2.req_addr   = reqAddr;
  assign bus2.req_wdata  = reqWdata;
  assign bus2.req_be     = reqBe;
  assign bus2.resp_ready = respReady;
  assign bus4.req_valid  = reqValid;
  assign bus4.req_write  = reqWrite;
  assign bus4.req_addr   = reqAddr;
  assign bus4.req_wdata  = reqWdata;
  assign bus4.req_be     = reqBe;
  assign bus4.resp_ready = respReady;

  data_mem_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .err_count(errCount2)
  );

  data_mem_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(4)
  ) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .err_count(errCount4)
  );

  assign reqReady  = sel ? bus4.req_ready  : bus2.req_ready;
  assign respValid = sel ? bus4.resp_valid : bus2.resp_valid;
  assign respRdata = sel ? bus4.resp_rdata : bus2.resp_rdata;
  assign respErr   = sel ? bus4.resp_err   : bus2.resp_err;
  assign errCount  = sel ? errCount4       : errCount2;
  assign rstSel    = sel ? rst4            : rst2;

  always @(posedge clk) cycle <= cycle + 1;

  // One comparison: bumps the totals and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, actual, expected, cycle);
  endtask

  // Transaction-level model: one outstanding request, which becomes visible
  // LATENCY cycles after its handshake and updates memory at that moment.
  bit          checkEn     = 1'b1;
  logic        rstSampled  = 1'b0;
  bit          pending     = 1'b0;
  int          dueCycle    = 0;
  bit          expWrite;
  logic [31:0] expAddr;
  logic [31:0] expWdata;
  logic [3:0]  expBe;
  logic [31:0] expRdata    = 32'h0;
  bit          expErr      = 1'b0;
  bit          expKnown    = 1'b0;
  int          expErrCount = 0;
  int          modelIdx;
  logic [31:0] word;
  bit          expReady;
  bit          respShown;
  logic [31:0] modelMem [int];

  always @(negedge clk) begin
    if (checkEn) begin
      if (!rstSampled) begin
        pending     = 1'b0;
        expErrCount = 0;
      end
      if (pending && (cycle == dueCycle)) begin
        modelIdx = int'(expAddr >> 2);
        expErr   = (expAddr % 4 != 0) || (modelIdx >= 1024);
        expRdata = 32'h0;
        expKnown = 1'b1;
        if (expErr) begin
          if (expErrCount < 65535) expErrCount++;
        end else if (expWrite) begin
          if (expBe != 4'h0) begin
            if (modelMem.exists(modelIdx) || (expBe == 4'hF)) begin
              word = 32'h0;
              if (modelMem.exists(modelIdx)) word = modelMem[modelIdx];
              for (int b = 0; b < 4; b++)
                if (expBe[b]) word[8*b +: 8] = expWdata[8*b +: 8];
              modelMem[modelIdx] = word;
            end else begin
              modelMem.delete(modelIdx);
            end
          end
        end else begin
          expKnown = modelMem.exists(modelIdx);
          if (expKnown) expRdata = modelMem[modelIdx];
        end
      end
      expReady  = rstSampled && !pending;
      respShown = rstSampled && pending && (cycle >= dueCycle);
      checkOutput("req_ready",  32'(reqReady),  32'(expReady));
      checkOutput("resp_valid", 32'(respValid), 32'(respShown));
      checkOutput("err_count",  32'(errCount),  32'(expErrCount));
      if (respShown) begin
        if (expKnown) checkOutput("resp_rdata", respRdata, expRdata);
        checkOutput("resp_err", 32'(respErr), 32'(expErr));
      end
      if (respShown && respReady) begin
        pending = 1'b0;
      end else if (expReady && reqValid) begin
        pending  = 1'b1;
        dueCycle = cycle + (sel ? 4 : 2);
        expWrite = reqWrite;
        expAddr  = reqAddr;
        expWdata = reqWdata;
        expBe    = reqBe;
      end
    end
    rstSampled = rstSel;
  end

  int          lastLatency;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic [15:0] lastErrCount;

  // Waits (bounded) for req_ready at a falling edge; returns its cycle.
  task automatic waitHandshake(output int hsCycle);
    bit got = 1'b0;
    hsCycle = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (reqReady) begin
        got     = 1'b1;
        hsCycle = cycle;
      end
    end
    if (!got) begin
      nChecks++;
      $display("[TB] FAIL handshake: got no req_ready, expected one within 50 cycles");
    end
  endtask

  // Issues one request, waits for its response (resp_ready assumed high)
  // and records latency, data, error flag and error count seen with it.
  task automatic applyStimulus(input bit write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int hsCycle;
    bit got = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqWrite = write;
    reqAddr  = addr;
    reqWdata = wdata;
    reqBe    = be;
    waitHandshake(hsCycle);
    @(posedge clk); #1;
    reqValid = 1'b0;
    lastLatency = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (respValid) begin
        got          = 1'b1;
        lastLatency  = cycle - hsCycle;
        lastRdata    = respRdata;
        lastErr      = respErr;
        lastErrCount = errCount;
      end
    end
    if (!got) begin
      nChecks++;
      $display("[TB] FAIL response: got no resp_valid, expected one within 50 cycles");
    end
  endtask

  initial begin
    int hs;
    int spurious;
    sel = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = '0;
    respReady = 1'b1;

    // Reset of the LATENCY = 2 instance.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset req_ready",  32'(reqReady),  32'd0);
      checkOutput("reset resp_valid", 32'(respValid), 32'd0);
      checkOutput("reset err_count",  32'(errCount),  32'd0);
    end
    @(posedge clk); #1; rst2 = 1'b1;
    @(negedge clk);
    checkOutput("req_ready before release sampled", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("req_ready after release", 32'(reqReady), 32'd1);

    // Store then load.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checkOutput("store latency", 32'(lastLatency), 32'd2);
    checkOutput("store err", 32'(lastErr), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    checkOutput("load 0x10", lastRdata, 32'hDEADBEEF);
    checkOutput("load latency", 32'(lastLatency), 32'd2);

    // Byte enables.
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF);
    checkOutput("byte-lane merge", lastRdata, 32'h11BB33DD);

    // Errors and the last valid word.
    applyStimulus(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF);
    checkOutput("misaligned err", 32'(lastErr), 32'd1);
    checkOutput("misaligned rdata", lastRdata, 32'h0);
    checkOutput("misaligned err_count", 32'(lastErrCount), 32'd1);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0);
    checkOutput("no write on misaligned", lastRdata, 32'h11BB33DD);
    applyStimulus(1'b0, 32'h1000, 32'h0, 4'h0);
    checkOutput("out-of-range err", 32'(lastErr), 32'd1);
    checkOutput("out-of-range err_count", 32'(lastErrCount), 32'd2);
    applyStimulus(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF);
    checkOutput("last word store err", 32'(lastErr), 32'd0);
    applyStimulus(1'b0, 32'hFFC, 32'h0, 4'h0);
    checkOutput("last word load", lastRdata, 32'hCAFEF00D);

    // Store with no lanes enabled changes nothing.
    applyStimulus(1'b1, 32'h10, 32'h01234567, 4'h0);
    checkOutput("be=0 store err", 32'(lastErr), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    checkOutput("be=0 store kept data", lastRdata, 32'hDEADBEEF);

    // Backpressure with a new request waiting.
    @(posedge clk); #1;
    respReady = 1'b0;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h20; reqBe = 4'h0;
    waitHandshake(hs);
    @(posedge clk); #1; reqValid = 1'b0;
    for (int i = 0; i < 10 && !respValid; i++) @(negedge clk);
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h10;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp resp_valid held", 32'(respValid), 32'd1);
      checkOutput("bp rdata stable", respRdata, 32'h11BB33DD);
      checkOutput("bp req_ready low", 32'(reqReady), 32'd0);
    end
    @(posedge clk); #1; respReady = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    checkOutput("queued load after bp", lastRdata, 32'hDEADBEEF);

    // Switch to the LATENCY = 4 instance.
    @(posedge clk); #1; checkEn = 1'b0; rst2 = 1'b0; sel = 1'b1;
    modelMem.delete();
    @(posedge clk); #1; checkEn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst4 = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 32'h30, 32'h12345678, 4'hF);
    checkOutput("L4 store latency", 32'(lastLatency), 32'd4);

    // Reset during the second BUSY cycle of a store.
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h30; reqWdata = 32'h55; reqBe = 4'hF;
    waitHandshake(hs);
    @(posedge clk); #1; reqValid = 1'b0;
    @(posedge clk); #1; rst4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst4 = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (respValid) spurious++;
    end
    checkOutput("no spurious resp after reset", 32'(spurious), 32'd0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0);
    checkOutput("dropped store not committed", lastRdata, 32'h12345678);
    checkOutput("L4 load latency", 32'(lastLatency), 32'd4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
